// File: rtl/buff_pop_sched_pkg.sv
// ============================================================================
// Module  : buff_pop_sched_pkg
// Purpose : Default configuration, derived widths and the output entry type
//           for the buffer pop scheduler.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package buff_pop_sched_pkg;

    localparam int NUMELEM_DEF   = 4;
    localparam int BITDATA_DEF   = 4;
    localparam int NUMFIFO_DEF   = 8;
    localparam int POP_DELAY_DEF = 2;
    localparam int OUTDEPTH_DEF  = 4;

    localparam int BITFIFO = $clog2(NUMFIFO_DEF);
    localparam int BITELEM = $clog2(NUMELEM_DEF);
    localparam int BITCRED = $clog2(OUTDEPTH_DEF + 1);

    typedef struct packed {
        logic [BITFIFO-1:0]     prt;
        logic [BITDATA_DEF-1:0] dat;
    } out_entry_t;

endpackage

`default_nettype wire

// File: rtl/buff_rr_arb.sv
// ============================================================================
// Module  : buff_rr_arb
// Purpose : Round-robin arbiter; grants the first request at or above ptr,
//           wrapping from NUMFIFO-1 back to 0.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module buff_rr_arb #(
    parameter int NUMFIFO = 8,
    parameter int BITFIFO = 3
) (
    input  logic [NUMFIFO-1:0] req,
    input  logic [BITFIFO-1:0] ptr,
    output logic               gnt_vld,
    output logic [BITFIFO-1:0] gnt_idx
);

    localparam logic [BITFIFO-1:0] C_LAST = BITFIFO'(NUMFIFO - 1);

    logic [BITFIFO-1:0] w_scan;
    logic               w_found;

    always_comb begin
        gnt_idx = '0;
        w_found = 1'b0;
        w_scan  = ptr;
        for (int i = 0; i < NUMFIFO; i++) begin
            if (!w_found && req[w_scan]) begin
                gnt_idx = w_scan;
                w_found = 1'b1;
            end
            w_scan = (w_scan == C_LAST) ? '0 : w_scan + 1'b1;
        end
    end

    assign gnt_vld = |req;

endmodule

`default_nettype wire

// File: rtl/buff_pop_sched.sv
// ============================================================================
// Module  : buff_pop_sched
// Purpose : Push admission, credit-limited round-robin pop scheduling and
//           return realignment into an output FIFO for the static buffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module buff_pop_sched
    import buff_pop_sched_pkg::*;
#(
    parameter int NUMELEM   = NUMELEM_DEF,
    parameter int BITDATA   = BITDATA_DEF,
    parameter int NUMFIFO   = NUMFIFO_DEF,
    parameter int POP_DELAY = POP_DELAY_DEF,
    parameter int OUTDEPTH  = OUTDEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       buf_ready,
    input  logic                       in_vld,
    input  logic [$clog2(NUMFIFO)-1:0] in_prt,
    input  logic [BITDATA-1:0]         in_din,
    output logic                       in_rdy,
    output logic                       push,
    output logic [$clog2(NUMFIFO)-1:0] pu_prt,
    output logic [BITDATA-1:0]         pu_din,
    output logic                       pop,
    output logic [$clog2(NUMFIFO)-1:0] po_prt,
    input  logic [BITDATA-1:0]         po_dout,
    output logic                       out_vld,
    output logic [$clog2(NUMFIFO)-1:0] out_prt,
    output logic [BITDATA-1:0]         out_dat,
    input  logic                       out_rdy
);

    localparam int PRT_W  = $clog2(NUMFIFO);
    localparam int CNT_W  = $clog2(NUMELEM) + 1;
    localparam int CRED_W = $clog2(OUTDEPTH + 1);
    localparam int ADR_W  = (OUTDEPTH > 1) ? $clog2(OUTDEPTH) : 1;

    localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(NUMELEM);
    localparam logic [CRED_W-1:0] C_DEPTH  = CRED_W'(OUTDEPTH);
    localparam logic [PRT_W-1:0]  C_LAST_Q = PRT_W'(NUMFIFO - 1);
    localparam logic [ADR_W-1:0]  C_LAST_A = ADR_W'(OUTDEPTH - 1);

    typedef struct packed {
        logic [PRT_W-1:0]   prt;
        logic [BITDATA-1:0] dat;
    } entry_t;

    logic [CNT_W-1:0]     r_cnt [NUMFIFO];
    logic [PRT_W-1:0]     r_rr_ptr;
    logic [POP_DELAY-1:0] r_pipe_vld;
    logic [PRT_W-1:0]     r_pipe_prt [POP_DELAY];
    entry_t               r_mem [OUTDEPTH];
    logic [ADR_W-1:0]     r_wr_adr;
    logic [ADR_W-1:0]     r_rd_adr;
    logic [CRED_W-1:0]    r_occ;

    logic [NUMFIFO-1:0]   w_req;
    logic                 w_gnt_vld;
    logic [PRT_W-1:0]     w_gnt_idx;
    logic [CRED_W-1:0]    w_inflight;
    logic                 w_has_credit;
    logic                 w_in_rdy;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ret_vld;
    logic                 w_rd;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < POP_DELAY; i++) begin
            w_inflight = w_inflight + CRED_W'(r_pipe_vld[i]);
        end
        for (int q = 0; q < NUMFIFO; q++) begin
            w_req[q] = (r_cnt[q] != '0);
        end
    end

    buff_rr_arb #(
        .NUMFIFO (NUMFIFO),
        .BITFIFO (PRT_W)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    // Credits cover both FIFO residents and pops still travelling through the buffer.
    assign w_has_credit = (r_occ + w_inflight) < C_DEPTH;

    assign w_in_rdy  = !rst && buf_ready && (r_cnt[in_prt] < C_FULL);
    assign w_push    = in_vld && w_in_rdy;
    assign w_pop     = !rst && buf_ready && w_has_credit && w_gnt_vld;
    assign w_ret_vld = r_pipe_vld[POP_DELAY-1];
    assign w_rd      = (r_occ != '0) && out_rdy;

    assign in_rdy  = w_in_rdy;
    assign push    = w_push;
    assign pu_prt  = rst ? '0 : in_prt;
    assign pu_din  = rst ? '0 : in_din;
    assign pop     = w_pop;
    assign po_prt  = rst ? '0 : w_gnt_idx;
    assign out_vld = !rst && (r_occ != '0);
    assign out_prt = rst ? '0 : r_mem[r_rd_adr].prt;
    assign out_dat = rst ? '0 : r_mem[r_rd_adr].dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NUMFIFO; q++) begin
                r_cnt[q] <= '0;
            end
            for (int i = 0; i < POP_DELAY; i++) begin
                r_pipe_prt[i] <= '0;
            end
            r_rr_ptr   <= '0;
            r_pipe_vld <= '0;
            r_wr_adr   <= '0;
            r_rd_adr   <= '0;
            r_occ      <= '0;
        end else begin
            for (int q = 0; q < NUMFIFO; q++) begin
                r_cnt[q] <= r_cnt[q]
                          + CNT_W'(w_push && (pu_prt == PRT_W'(q)))
                          - CNT_W'(w_pop && (w_gnt_idx == PRT_W'(q)));
            end
            if (w_pop) begin
                r_rr_ptr <= (w_gnt_idx == C_LAST_Q) ? '0 : w_gnt_idx + 1'b1;
            end
            r_pipe_vld[0] <= w_pop;
            r_pipe_prt[0] <= w_gnt_idx;
            for (int i = 1; i < POP_DELAY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_prt[i] <= r_pipe_prt[i-1];
            end
            if (w_ret_vld) begin
                r_wr_adr <= (r_wr_adr == C_LAST_A) ? '0 : r_wr_adr + 1'b1;
            end
            if (w_rd) begin
                r_rd_adr <= (r_rd_adr == C_LAST_A) ? '0 : r_rd_adr + 1'b1;
            end
            r_occ <= r_occ + CRED_W'(w_ret_vld) - CRED_W'(w_rd);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && w_ret_vld) begin
            r_mem[r_wr_adr] <= '{prt: r_pipe_prt[POP_DELAY-1], dat: po_dout};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buff_pop_sched.sv
// ============================================================================
// Module  : tb_buff_pop_sched
// Purpose : Scoreboard bench for buff_pop_sched with a behavioural buffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_buff_pop_sched;
    import buff_pop_sched_pkg::*;

    localparam int NQ = 8;
    localparam int NE = 4;
    localparam int PD = 2;
    localparam int OD = 4;

    logic       clk = 1'b0;
    logic       rst, buf_ready, in_vld, in_rdy, push, pop, out_vld, out_rdy;
    logic [2:0] in_prt, pu_prt, po_prt, out_prt;
    logic [3:0] in_din, pu_din, po_dout, out_dat;

    always #5 clk = ~clk;

    buff_pop_sched dut (
        .clk       (clk),
        .rst       (rst),
        .buf_ready (buf_ready),
        .in_vld    (in_vld),
        .in_prt    (in_prt),
        .in_din    (in_din),
        .in_rdy    (in_rdy),
        .push      (push),
        .pu_prt    (pu_prt),
        .pu_din    (pu_din),
        .pop       (pop),
        .po_prt    (po_prt),
        .po_dout   (po_dout),
        .out_vld   (out_vld),
        .out_prt   (out_prt),
        .out_dat   (out_dat),
        .out_rdy   (out_rdy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0]  bq [NQ][$];
    logic [3:0]  dl [PD];
    out_entry_t  exp_q[$];
    logic [6:0]  got[$];
    logic [6:0]  want[$];
    int          pop_log[$];
    int          pop_cyc[$];

    logic s_in_rdy, s_push, s_pop, s_out_vld;
    logic [2:0] s_po_prt;
    logic lat_arm = 1'b0;
    int   first_pop, first_out;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] ent(input int p, input int d);
        return {3'(p), 4'(d)};
    endfunction

    function automatic bit model_idle();
        bit idle = (exp_q.size() == 0);
        for (int q = 0; q < NQ; q++) if (bq[q].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    // One clock: sample after inputs settle, update the model, realign po_dout.
    task automatic step();
        out_entry_t e;
        logic [3:0] d;
        bit         popped = 1'b0;
        d = '0;
        #1;
        s_in_rdy  = in_rdy;
        s_push    = push;
        s_pop     = pop;
        s_po_prt  = po_prt;
        s_out_vld = out_vld;
        if (rst)
            chk("rst_zero", 32'({in_rdy, push, pop, out_vld, pu_prt, pu_din, po_prt, out_prt, out_dat}), 0);
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("out_unexp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_prt", 32'(out_prt), 32'(e.prt));
                chk("out_dat", 32'(out_dat), 32'(e.dat));
            end
            got.push_back({out_prt, out_dat});
        end
        if (out_vld && lat_arm && first_out < 0) first_out = cyc;
        if (pop) begin
            if (bq[po_prt].size() == 0) begin
                chk("pop_empty", 1, 0);
            end else begin
                d = bq[po_prt].pop_front();
                popped = 1'b1;
                exp_q.push_back('{prt: po_prt, dat: d});
                pop_log.push_back(int'(po_prt));
                pop_cyc.push_back(cyc);
                if (lat_arm && first_pop < 0) first_pop = cyc;
            end
        end
        if (push) begin
            if (bq[pu_prt].size() >= NE) chk("push_full", 1, 0);
            bq[pu_prt].push_back(pu_din);
        end
        chk("credit_bound", 32'(exp_q.size() <= OD), 1);
        @(posedge clk);
        if (rst) begin
            for (int q = 0; q < NQ; q++) bq[q].delete();
            exp_q.delete();
        end
        @(negedge clk);
        for (int k = PD - 1; k > 0; k--) dl[k] = dl[k-1];
        dl[0]   = popped ? d : 4'($urandom);
        po_dout = dl[PD-1];
        cyc++;
    endtask

    task automatic check_cnts(input string tag);
        for (int q = 0; q < NQ; q++) chk(tag, 32'(dut.r_cnt[q]), 32'(bq[q].size()));
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (model_idle() && !out_vld) break;
            step();
        end
        chk("drain_done", 32'(model_idle() && !out_vld), 1);
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, "_n"}, got.size(), want.size());
        for (int i = 0; i < got.size() && i < want.size(); i++)
            chk(tag, 32'(got[i]), 32'(want[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst = 1'b1; buf_ready = 1'b1; in_vld = 1'b1; in_prt = 3'd3; in_din = 4'd5;
        out_rdy = 1'b1; po_dout = '0;
        for (int k = 0; k < PD; k++) dl[k] = '0;
        @(negedge clk);
        step(); step();
        rst = 1'b0; in_vld = 1'b0;
        step(); step();
        chk("idle_rdy", 32'(s_in_rdy), 1);
        chk("idle_pop", 32'(s_pop), 0);
        chk("idle_vld", 32'(s_out_vld), 0);
        for (int q = 0; q < NQ; q++) chk("idle_cnt", 32'(dut.r_cnt[q]), 0);
        buf_ready = 1'b0; in_vld = 1'b1;
        step();
        chk("nbr_rdy", 32'(s_in_rdy), 0);
        chk("nbr_push", 32'(s_push), 0);
        in_vld = 1'b0; buf_ready = 1'b1;

        // Fill queue 3 to capacity behind a credit-exhausted output FIFO.
        got.delete(); out_rdy = 1'b0;
        in_vld = 1'b1; in_prt = 3'd0;
        for (int i = 0; i < 4; i++) begin in_din = 4'(10 + i); step(); end
        in_vld = 1'b0;
        repeat (6) step();
        chk("t1_no_credit", 32'(s_pop), 0);
        chk("t1_fifo_vld", 32'(s_out_vld), 1);
        in_vld = 1'b1; in_prt = 3'd3;
        for (int i = 1; i <= 4; i++) begin in_din = 4'(i); step(); chk("t1_push", 32'(s_push), 1); end
        in_din = 4'd5;
        step();
        chk("t1_full_rdy", 32'(s_in_rdy), 0);
        chk("t1_full_push", 32'(s_push), 0);
        step();
        chk("t1_full_push2", 32'(s_push), 0);
        chk("t1_cnt3", 32'(dut.r_cnt[3]), 4);
        check_cnts("t1_cnt");
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin step(); if (s_push) break; end
        chk("t1_5th_push", 32'(s_push), 1);
        drain();
        want = '{ent(0,10), ent(0,11), ent(0,12), ent(0,13),
                 ent(3,1), ent(3,2), ent(3,3), ent(3,4), ent(3,5)};
        cmp_got("t1_out");

        // Pop-to-output latency on an idle system.
        got.delete(); first_pop = -1; first_out = -1; lat_arm = 1'b1;
        in_vld = 1'b1; in_prt = 3'd4; in_din = 4'd6;
        step();
        in_vld = 1'b0;
        repeat (8) step();
        lat_arm = 1'b0;
        chk("t2_latency", 32'(first_out - first_pop), PD + 1);
        drain();
        want = '{ent(4,6)};
        cmp_got("t2_out");

        // Round-robin from rr_ptr=1 across queues 0, 2, 7.
        got.delete(); out_rdy = 1'b0;
        in_vld = 1'b1; in_prt = 3'd0;
        for (int i = 1; i <= 4; i++) begin in_din = 4'(i); step(); end
        in_vld = 1'b0;
        repeat (6) step();
        in_vld = 1'b1;
        in_prt = 3'd0; in_din = 4'd10; step();
        in_prt = 3'd2; in_din = 4'd11; step();
        in_prt = 3'd7; in_din = 4'd12; step();
        chk("t3_held", 32'(s_pop), 0);
        drain();
        want = '{ent(0,1), ent(0,2), ent(0,3), ent(0,4), ent(2,11), ent(7,12), ent(0,10)};
        cmp_got("t3_out");

        // Push and pop to queue 5 in the same cycle.
        got.delete(); out_rdy = 1'b0;
        in_vld = 1'b1; in_prt = 3'd1;
        for (int i = 1; i <= 4; i++) begin in_din = 4'(i); step(); end
        in_vld = 1'b0;
        repeat (6) step();
        in_vld = 1'b1; in_prt = 3'd5; in_din = 4'd8;
        step();
        in_vld = 1'b0;
        step();
        chk("t4_blocked", 32'(s_pop), 0);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0; in_vld = 1'b1; in_prt = 3'd5; in_din = 4'd9;
        step();
        chk("t4_pop", 32'(s_pop), 1);
        chk("t4_push", 32'(s_push), 1);
        chk("t4_po_prt", 32'(s_po_prt), 5);
        in_vld = 1'b0;
        step();
        chk("t4_cnt5", 32'(dut.r_cnt[5]), 1);
        check_cnts("t4_cnt");
        drain();
        want = '{ent(1,1), ent(1,2), ent(1,3), ent(1,4), ent(5,8), ent(5,9)};
        cmp_got("t4_out");

        // Eight entries behind a stalled consumer: exactly OUTDEPTH pops.
        got.delete(); pop_log.delete(); pop_cyc.delete(); out_rdy = 1'b0;
        in_vld = 1'b1;
        for (int q = 0; q < NQ; q++) begin in_prt = 3'(q); in_din = 4'(q + 1); step(); end
        in_vld = 1'b0;
        repeat (6) step();
        chk("t5_npop", pop_log.size(), OD);
        chk("t5_stalled", 32'(s_pop), 0);
        out_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin if (pop_log.size() >= NQ) break; step(); end
        chk("t5_all_popped", pop_log.size(), NQ);
        if (pop_cyc.size() >= NQ) chk("t5_rate", 32'(pop_cyc[NQ-1] - pop_cyc[OD]), NQ - OD - 1);
        drain();
        want.delete();
        for (int q = 0; q < NQ; q++) want.push_back(ent(q, q + 1));
        cmp_got("t5_out");

        // Reset while a pop is in flight.
        out_rdy = 1'b1; in_vld = 1'b1; in_prt = 3'd2; in_din = 4'd7;
        step();
        in_vld = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (s_pop) break; end
        chk("t6_popped", 32'(s_pop), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_vld", 32'(s_out_vld), 0);
        for (int q = 0; q < NQ; q++) chk("t6_cnt", 32'(dut.r_cnt[q]), 0);
        nv = 0;
        repeat (6) begin step(); nv += int'(s_out_vld); end
        chk("t6_no_stale", nv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
